// File: rtl/rs_station_if.sv
// Dispatch, CDB and issue signals of the reservation station.
// slave: the station's view; master: the dispatch/CDB/execute side.
interface rs_station_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    // dispatch
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_unit;
    logic [9:0]       in_op;
    logic [31:0]      in_pc;
    logic             in_rj;
    logic             in_rk;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;
    logic [TAG_W-1:0] in_qj;
    logic [TAG_W-1:0] in_qk;
    logic [TAG_W-1:0] in_dest;
    // common data bus
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    // issue to execute
    logic             ex_valid;
    logic             ex_ready;
    logic [2:0]       ex_unit;
    logic [9:0]       ex_op;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_vj;
    logic [31:0]      ex_vk;
    logic [TAG_W-1:0] ex_dest;
    logic [CW-1:0]    count;

    modport slave (
        input  flush, in_valid, in_unit, in_op, in_pc, in_rj, in_rk, in_vj, in_vk,
               in_qj, in_qk, in_dest, cdb_valid, cdb_tag, cdb_value, ex_ready,
        output in_ready, ex_valid, ex_unit, ex_op, ex_pc, ex_vj, ex_vk, ex_dest, count
    );

    modport master (
        output flush, in_valid, in_unit, in_op, in_pc, in_rj, in_rk, in_vj, in_vk,
               in_qj, in_qk, in_dest, cdb_valid, cdb_tag, cdb_value, ex_ready,
        input  in_ready, ex_valid, ex_unit, ex_op, ex_pc, ex_vj, ex_vk, ex_dest, count
    );
endinterface

// File: rtl/rs_station.sv
// Reservation station: age-ordered collapsing queue (slot 0 oldest) that snoops the
// CDB for pending operands and issues the oldest ready µop into a registered
// valid/ready output stage. Optional macro RS_BYPASS_EN lets a ready dispatch skip
// the queue and load the output register directly when nothing queued is ready.
module rs_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rs_station_if.slave  rif
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]       unit;
        logic [9:0]       op;
        logic [31:0]      pc;
        logic             rj;
        logic             rk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
    } ent_t;

    typedef struct packed {
        logic             valid;
        logic [2:0]       unit;
        logic [9:0]       op;
        logic [31:0]      pc;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] dest;
    } ex_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    ex_t           ex_q, ex_d;
    logic [CW-1:0] count_q, count_d;

    // Working values; snp has one spare zero slot so the collapse can read i+1 freely.
    ent_t          snp [DEPTH+1];
    ent_t          new_ent;
    ent_t          sel_ent;
    int            sel_idx;
    logic          sel_found, out_free, issue, in_acc, bypass, wr_en;
    logic [CW-1:0] wr_idx;

    // Next-state: CDB snoop, oldest-ready select, collapse/insert, output stage, flush.
    always_comb begin
        // NOTE: every variable gets a default before any branch; otherwise a path that skips it infers a latch.
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_ent   = '0;
        bypass    = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = ent_q[i];
            if (rif.cdb_valid && !ent_q[i].rj && ent_q[i].qj == rif.cdb_tag) begin
                snp[i].rj = 1'b1;
                snp[i].vj = rif.cdb_value;
            end
            if (rif.cdb_valid && !ent_q[i].rk && ent_q[i].qk == rif.cdb_tag) begin
                snp[i].rk = 1'b1;
                snp[i].vk = rif.cdb_value;
            end
        end
        snp[DEPTH] = '0;

        // Incoming µop, with same-cycle CDB capture on either or both operands.
        new_ent.unit = rif.in_unit;
        new_ent.op   = rif.in_op;
        new_ent.pc   = rif.in_pc;
        new_ent.qj   = rif.in_qj;
        new_ent.qk   = rif.in_qk;
        new_ent.dest = rif.in_dest;
        new_ent.rj   = rif.in_rj;
        new_ent.vj   = rif.in_vj;
        new_ent.rk   = rif.in_rk;
        new_ent.vk   = rif.in_vk;
        if (rif.cdb_valid && !rif.in_rj && rif.in_qj == rif.cdb_tag) begin
            new_ent.rj = 1'b1;
            new_ent.vj = rif.cdb_value;
        end
        if (rif.cdb_valid && !rif.in_rk && rif.in_qk == rif.cdb_tag) begin
            new_ent.rk = 1'b1;
            new_ent.vk = rif.cdb_value;
        end

        // Selection looks at registered ready bits only, so a capture is usable next cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && CW'(i) < count_q && ent_q[i].rj && ent_q[i].rk) begin
                sel_found = 1'b1;
                sel_idx   = i;
                sel_ent   = ent_q[i];
            end
        end

        out_free = !ex_q.valid || rif.ex_ready;
        issue    = sel_found && out_free;
        // Full refusal is based on count_q alone, even if an issue frees a slot this cycle.
        in_acc   = rif.in_valid && (count_q < CW'(DEPTH));
`ifdef RS_BYPASS_EN
        bypass   = in_acc && !sel_found && out_free && new_ent.rj && new_ent.rk;
`endif
        wr_en    = in_acc && !bypass;
        wr_idx   = count_q - CW'(issue);

        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (issue && i >= sel_idx) ? snp[i+1] : snp[i];
            if (wr_en && CW'(i) == wr_idx) begin
                ent_d[i] = new_ent;
            end
        end
        count_d = count_q - CW'(issue) + CW'(wr_en);

        ex_d = ex_q;
        if (issue) begin
            ex_d = '{valid: 1'b1, unit: sel_ent.unit, op: sel_ent.op, pc: sel_ent.pc,
                     vj: sel_ent.vj, vk: sel_ent.vk, dest: sel_ent.dest};
        end else if (bypass) begin
            ex_d = '{valid: 1'b1, unit: new_ent.unit, op: new_ent.op, pc: new_ent.pc,
                     vj: new_ent.vj, vk: new_ent.vk, dest: new_ent.dest};
        end else if (rif.ex_ready) begin
            ex_d.valid = 1'b0;
        end

        // Flush overrides dispatch, CDB capture and issue.
        if (rif.flush) begin
            ex_d    = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ex_q    <= '0;
            // NOTE: slots past count are don't-care, but the array is tiny, so it is reset for deterministic contents.
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            count_q <= count_d;
            ex_q    <= ex_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign rif.in_ready = (count_q < CW'(DEPTH));
    assign rif.count    = count_q;
    assign rif.ex_valid = ex_q.valid;
    assign rif.ex_unit  = ex_q.unit;
    assign rif.ex_op    = ex_q.op;
    assign rif.ex_pc    = ex_q.pc;
    assign rif.ex_vj    = ex_q.vj;
    assign rif.ex_vk    = ex_q.vk;
    assign rif.ex_dest  = ex_q.dest;
endmodule
